lcd_cmd_sequencer: RTL

//  Command initiator for the LCD image controller's cmd/cmd_valid/busy/done interface.
//  - On start, fetches 4-bit opcodes from a command script ROM (CROM).
//  - Issues each opcode to the controller as a one-cycle cmd_valid pulse, only while the controller's busy is low.
//  - After a Write opcode it waits for the controller's done.
//  - Sits between the testbench/host and the LCD controller, replacing hand-driven command stimulus.

---
 rtl/lcd_pkg.sv | 38 +++
 rtl/seq_watchdog.sv | 48 ++++
 rtl/lcd_cmd_sequencer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command sequencer.
//   - Opcode values understood by the LCD image controller, plus the
//     script-only opcodes (NOPs and END) that the sequencer consumes itself.
//   - Sequencer FSM state encoding. It is also driven out on dbg_state.
//   - is_nop(): identifies opcodes that are skipped without being issued.
package lcd_pkg;

  localparam logic [3:0] CMD_WRITE     = 4'h0;
  localparam logic [3:0] CMD_SHIFT_UP  = 4'h1;
  localparam logic [3:0] CMD_SHIFT_DN  = 4'h2;
  localparam logic [3:0] CMD_SHIFT_LF  = 4'h3;
  localparam logic [3:0] CMD_SHIFT_RT  = 4'h4;
  localparam logic [3:0] CMD_MAX       = 4'h5;
  localparam logic [3:0] CMD_MIN       = 4'h6;
  localparam logic [3:0] CMD_AVG       = 4'h7;
  localparam logic [3:0] CMD_ROT_CCW   = 4'h8;
  localparam logic [3:0] CMD_ROT_CW    = 4'h9;
  localparam logic [3:0] CMD_MIRROR_X  = 4'hA;
  localparam logic [3:0] CMD_MIRROR_Y  = 4'hB;
  localparam logic [3:0] CMD_LOAD      = 4'hC;
  localparam logic [3:0] CMD_NOP0      = 4'hD;
  localparam logic [3:0] CMD_NOP1      = 4'hE;
  localparam logic [3:0] CMD_END       = 4'hF;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_RDY  = 3'd1;
  localparam logic [2:0] ST_FETCH     = 3'd2;
  localparam logic [2:0] ST_DECODE    = 3'd3;
  localparam logic [2:0] ST_ISSUE     = 3'd4;
  localparam logic [2:0] ST_SETTLE    = 3'd5;
  localparam logic [2:0] ST_WAIT_DONE = 3'd6;
  localparam logic [2:0] ST_FINISH    = 3'd7;

  function automatic logic is_nop(input logic [3:0] op);
    return (op == CMD_NOP0) || (op == CMD_NOP1);
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Wait-state watchdog for the LCD command sequencer.
// The counter is cleared while clr is high. It advances by one each cycle
// while en is high. expired is high in the cycle where the count has reached
// BUSY_TIMEOUT-1 and en is still high. The owner then leaves its wait state
// on that edge, so it has spent exactly BUSY_TIMEOUT cycles waiting.
// Ports:
//   clk, reset_n : clock and async active-low reset
//   clr          : hold the count at zero
//   en           : count this cycle
//   expired      : timeout reached (combinational from the count flop)
module seq_watchdog
  import lcd_pkg::*;
#(
  parameter int BUSY_TIMEOUT = 1024,
  parameter int TO_W         = 11
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(BUSY_TIMEOUT - 1);
  localparam logic [TO_W-1:0] CNT_ONE  = {{(TO_W-1){1'b0}}, 1'b1};

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && !clr && (cnt_q == CNT_LAST);

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// LCD command sequencer.
// After a start pulse, the sequencer reads opcodes from the command script ROM.
// It issues each opcode to the LCD controller as a one-cycle cmd_valid pulse.
// Handshake: cmd_valid is an issue-only strobe with no acknowledge. The
// controller's lcd_busy acts as "not ready". The sequencer samples lcd_busy==0
// in WAIT_RDY and only then starts a fetch, so a pulse never overlaps busy.
// SETTLE gives the controller one cycle to raise busy before the next check.
// A Write (opcode 0) ends the script once lcd_done is seen. END (F) also ends
// the script. NOPs (D/E) are skipped. All outputs come straight from flops.
// Ports:
//   clk, reset_n        : clock, async active-low reset
//   start               : 1-cycle pulse, run the script from address 0
//   CROM_rd/A, CROM_Q   : script ROM port; Q is valid the cycle after rd
//   lcd_busy, lcd_done  : controller status
//   cmd, cmd_valid      : opcode and issue strobe to the controller
//   seq_busy, seq_done  : running flag / sticky finished flag
//   error               : sticky timeout or script overrun
//   cmd_count           : opcodes issued in this run (saturating)
//   dbg_state           : current FSM state
module lcd_cmd_sequencer
  import lcd_pkg::*;
#(
  parameter int CMD_AW       = 6,
  parameter int BUSY_TIMEOUT = 1024,
  parameter int TO_W         = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              CROM_rd,
  output logic [CMD_AW-1:0] CROM_A,
  input  logic [3:0]        CROM_Q,
  input  logic              lcd_busy,
  input  logic              lcd_done,
  output logic [3:0]        cmd,
  output logic              cmd_valid,
  output logic              seq_busy,
  output logic              seq_done,
  output logic              error,
  output logic [CMD_AW:0]   cmd_count,
  output logic [2:0]        dbg_state
);

  localparam logic [CMD_AW-1:0] ADDR_LAST = {CMD_AW{1'b1}};
  localparam logic [CMD_AW-1:0] ADDR_ONE  = {{(CMD_AW-1){1'b0}}, 1'b1};
  localparam logic [CMD_AW:0]   CNT_MAX   = {1'b1, {CMD_AW{1'b0}}};
  localparam logic [CMD_AW:0]   CNT_ONE   = {{CMD_AW{1'b0}}, 1'b1};

  logic [2:0]        state_q, state_d;
  logic [CMD_AW-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic [3:0]        cmd_q, cmd_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              seq_busy_q, seq_busy_d;
  logic              seq_done_q, seq_done_d;
  logic              error_q, error_d;
  logic [CMD_AW:0]   count_q, count_d;
  logic              advance;
  logic              wd_clr, wd_en, wd_expired;

  // The watchdog runs only in the two wait states. It is held clear everywhere
  // else, so it always starts from zero when one of them is entered.
  assign wd_en  = (state_q == ST_WAIT_RDY) || (state_q == ST_WAIT_DONE);
  assign wd_clr = !wd_en;

  seq_watchdog #(
    .BUSY_TIMEOUT (BUSY_TIMEOUT),
    .TO_W         (TO_W)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rd_d        = 1'b0;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    seq_busy_d  = seq_busy_q;
    seq_done_d  = seq_done_q;
    error_d     = error_q;
    count_d     = count_q;
    advance     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_WAIT_RDY;
          seq_busy_d = 1'b1;
          seq_done_d = 1'b0;
          count_d    = '0;
          addr_d     = '0;
        end
      end
      ST_WAIT_RDY: begin
        // lcd_done is ignored here on purpose; only busy matters.
        if (!lcd_busy) begin
          state_d = ST_FETCH;
          rd_d    = 1'b1;
        end else if (wd_expired) begin
          state_d    = ST_IDLE;
          error_d    = 1'b1;
          seq_busy_d = 1'b0;
          seq_done_d = 1'b0;
        end
      end
      ST_FETCH: begin
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (CROM_Q == CMD_END) begin
          state_d = ST_FINISH;
        end else if (is_nop(CROM_Q)) begin
          advance = 1'b1;
        end else begin
          state_d     = ST_ISSUE;
          cmd_d       = CROM_Q;
          cmd_valid_d = 1'b1;
          if (count_q != CNT_MAX) begin
            count_d = count_q + CNT_ONE;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        // cmd_q still holds the opcode that was just issued.
        if (cmd_q == CMD_WRITE) begin
          state_d = ST_WAIT_DONE;
        end else begin
          advance = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (lcd_done) begin
          state_d = ST_FINISH;
        end else if (wd_expired) begin
          state_d    = ST_IDLE;
          error_d    = 1'b1;
          seq_busy_d = 1'b0;
          seq_done_d = 1'b0;
        end
      end
      ST_FINISH: begin
        // Returns to IDLE without looking at start, so a start pulse in this
        // cycle is dropped.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Moving past the last ROM word is a script overrun. The address does not wrap.
    if (advance) begin
      if (addr_q == ADDR_LAST) begin
        error_d = 1'b1;
        state_d = ST_FINISH;
      end else begin
        addr_d  = addr_q + ADDR_ONE;
        state_d = ST_WAIT_RDY;
      end
    end

    if (state_d == ST_FINISH) begin
      seq_done_d = 1'b1;
      seq_busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      cmd_q       <= 4'h0;
      cmd_valid_q <= 1'b0;
      seq_busy_q  <= 1'b0;
      seq_done_q  <= 1'b0;
      error_q     <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      seq_busy_q  <= seq_busy_d;
      seq_done_q  <= seq_done_d;
      error_q     <= error_d;
      count_q     <= count_d;
    end
  end

  assign CROM_rd   = rd_q;
  assign CROM_A    = addr_q;
  assign cmd       = cmd_q;
  assign cmd_valid = cmd_valid_q;
  assign seq_busy  = seq_busy_q;
  assign seq_done  = seq_done_q;
  assign error     = error_q;
  assign cmd_count = count_q;
  assign dbg_state = state_q;

endmodule
